ddr_rd_prefetch: RTL and testbench



---
 rtl/ddr_rd_prefetch.sv | 167 ++++++++++++++++
 tb/tb_ddr_rd_prefetch.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_rd_prefetch.sv
// rtl/ddr_rd_prefetch.sv - frame-synchronous DDR burst-read prefetcher feeding a FWFT pixel FIFO
module ddr_rd_prefetch #(
   parameter int                ADDR_W      = 24,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
   parameter int                FIFO_DEPTH  = 512,
   parameter int                BURST_LEN   = 64,
   parameter int                FRAME_WORDS = 153600
) (
   input  logic                        vga_clk,
   input  logic                        vga_rst_n,
   input  logic                        ddr_init_done,
   input  logic                        frame_start,
   output logic                        rd_burst_req,
   output logic [ADDR_W-1:0]           rd_burst_addr,
   output logic [8:0]                  rd_burst_len,
   input  logic                        rd_burst_ack,
   input  logic                        rd_data_valid,
   input  logic [31:0]                 rd_data,
   input  logic                        pix_rden,
   output logic [31:0]                 pix_data,
   output logic                        pix_empty,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic                        underflow
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = PW + 1;
   localparam int IW = $clog2(FRAME_WORDS + 1);

   typedef enum logic [2:0] {IDLE, CHECK, REQ, DATA, FLUSH, DONE} state_t;

   state_t            state, state_n;
   logic [ADDR_W-1:0] addr_n;
   logic [8:0]        len_n;
   logic [IW-1:0]     issued, issued_n;
   logic [8:0]        beat, beat_n;
   logic              burst_end;
   logic              fifo_clr;
   logic              push;
   logic              pop;
   int                remaining;
   int                free_words;

   logic [31:0]       mem [FIFO_DEPTH];
   logic [PW-1:0]     wr_ptr, rd_ptr;

   assign rd_burst_req = (state == REQ);
   assign remaining    = FRAME_WORDS - int'(issued);
   assign free_words   = FIFO_DEPTH - int'(fifo_level);
   assign burst_end    = rd_data_valid && ((beat + 9'd1) == rd_burst_len);

   always_ff @(posedge vga_clk or negedge vga_rst_n) begin
      if (!vga_rst_n) begin
         state         <= IDLE;
         rd_burst_addr <= BASE_ADDR;
         rd_burst_len  <= '0;
         issued        <= '0;
         beat          <= '0;
      end else begin
         state         <= state_n;
         rd_burst_addr <= addr_n;
         rd_burst_len  <= len_n;
         issued        <= issued_n;
         beat          <= beat_n;
      end
   end

   always_comb begin
      state_n  = state;
      addr_n   = rd_burst_addr;
      len_n    = rd_burst_len;
      issued_n = issued;
      beat_n   = beat;
      fifo_clr = 1'b0;
      push     = 1'b0;
      case (state)
         IDLE: begin
            if (frame_start && ddr_init_done) begin
               state_n  = CHECK;
               fifo_clr = 1'b1;
               issued_n = '0;
               addr_n   = BASE_ADDR;
            end
         end
         CHECK: begin
            if (remaining == 0) begin
               state_n = DONE;
            end else if (free_words >= BURST_LEN) begin
               // FIFO space for the whole burst is reserved here, so DATA never overflows
               state_n = REQ;
               len_n   = (remaining < BURST_LEN) ? 9'(remaining) : 9'(BURST_LEN);
            end
         end
         REQ: begin
            if (rd_burst_ack) begin
               state_n = DATA;
               beat_n  = '0;
            end
         end
         DATA: begin
            if (rd_data_valid) begin
               push   = 1'b1;
               beat_n = beat + 9'd1;
               if (burst_end) begin
                  state_n  = CHECK;
                  addr_n   = rd_burst_addr + ADDR_W'(rd_burst_len);
                  issued_n = issued + IW'(rd_burst_len);
               end
            end
         end
         FLUSH: begin
            if (rd_data_valid) begin
               beat_n = beat + 9'd1;
               if (burst_end) state_n = CHECK;
            end
         end
         DONE: begin
         end
         default: state_n = IDLE;
      endcase

      // A new frame restarts from the base; a burst already granted must still be drained
      if (frame_start && (state != IDLE)) begin
         fifo_clr = 1'b1;
         push     = 1'b0;
         issued_n = '0;
         addr_n   = BASE_ADDR;
         if (((state == DATA || state == FLUSH) && !burst_end) ||
             (state == REQ && rd_burst_ack))
            state_n = FLUSH;
         else
            state_n = CHECK;
      end
   end

   assign pop       = pix_rden && !pix_empty && !fifo_clr;
   assign pix_empty = (fifo_level == '0);
   assign pix_data  = pix_empty ? '0 : mem[rd_ptr];

   always_ff @(posedge vga_clk or negedge vga_rst_n) begin
      if (!vga_rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         underflow  <= 1'b0;
      end else if (fifo_clr) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         underflow  <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_level <= fifo_level + LW'(1);
            2'b01:   fifo_level <= fifo_level - LW'(1);
            default: fifo_level <= fifo_level;
         endcase
         if (pix_rden && pix_empty) underflow <= 1'b1;
      end
   end

   always_ff @(posedge vga_clk) begin
      if (push) mem[wr_ptr] <= rd_data;
   end

endmodule

// File: tb/tb_ddr_rd_prefetch.sv
// tb/tb_ddr_rd_prefetch.sv - directed self-checking bench for ddr_rd_prefetch
module tb_ddr_rd_prefetch;

   localparam int          AW    = 24;
   localparam int          DEPTH = 16;
   localparam int          BL    = 4;
   localparam logic [23:0] BASE  = 24'h100;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        init_done = 1'b0;
   logic        fs    [2];
   logic        ack   [2];
   logic        dv    [2];
   logic [31:0] dat   [2];
   logic        rden  [2];
   logic        req   [2];
   logic [23:0] addr  [2];
   logic [8:0]  len   [2];
   logic [31:0] pdata [2];
   logic        empty [2];
   logic [4:0]  level [2];
   logic        uflow [2];

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ddr_rd_prefetch #(.ADDR_W(AW), .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .BURST_LEN(BL),
                     .FRAME_WORDS(10)) u_dut0 (
      .vga_clk(clk), .vga_rst_n(rst_n), .ddr_init_done(init_done), .frame_start(fs[0]),
      .rd_burst_req(req[0]), .rd_burst_addr(addr[0]), .rd_burst_len(len[0]),
      .rd_burst_ack(ack[0]), .rd_data_valid(dv[0]), .rd_data(dat[0]), .pix_rden(rden[0]),
      .pix_data(pdata[0]), .pix_empty(empty[0]), .fifo_level(level[0]), .underflow(uflow[0]));

   ddr_rd_prefetch #(.ADDR_W(AW), .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .BURST_LEN(BL),
                     .FRAME_WORDS(40)) u_dut1 (
      .vga_clk(clk), .vga_rst_n(rst_n), .ddr_init_done(init_done), .frame_start(fs[1]),
      .rd_burst_req(req[1]), .rd_burst_addr(addr[1]), .rd_burst_len(len[1]),
      .rd_burst_ack(ack[1]), .rd_data_valid(dv[1]), .rd_data(dat[1]), .pix_rden(rden[1]),
      .pix_data(pdata[1]), .pix_empty(empty[1]), .fifo_level(level[1]), .underflow(uflow[1]));

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_frame(input int b);
      fs[b] = 1'b1;
      step();
      fs[b] = 1'b0;
   endtask

   task automatic wait_req(input int b, input int limit, output int cyc, output bit seen);
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc <= limit) begin
         if (req[b]) seen = 1'b1;
         else begin
            step();
            cyc++;
         end
      end
   endtask

   task automatic ack_req(input int b);
      ack[b] = 1'b1;
      step();
      ack[b] = 1'b0;
   endtask

   task automatic send_beats(input int b, input int n, input logic [31:0] d0);
      for (int i = 0; i < n; i++) begin
         dv[b]  = 1'b1;
         dat[b] = d0 + 32'(i);
         step();
      end
      dv[b] = 1'b0;
   endtask

   task automatic serve_frame(input int b);
      int  cyc;
      bit  seen;
      int  n;
      seen = 1'b1;
      while (seen) begin
         wait_req(b, 10, cyc, seen);
         if (seen) begin
            n = int'(len[b]);
            ack_req(b);
            send_beats(b, n, 32'hF00 + 32'(cyc));
         end
      end
   endtask

   task automatic test_reset;
      step(); step();
      checks++;
      if ({req[0], addr[0], len[0], pdata[0], empty[0], level[0], uflow[0]} !==
          {1'b0, BASE, 9'd0, 32'd0, 1'b1, 5'd0, 1'b0}) begin
         failures++;
         $display("FAIL reset_outputs got req=%b addr=%h len=%0d pdata=%h empty=%b level=%0d uflow=%b exp 0 100 0 0 1 0 0",
                  req[0], addr[0], len[0], pdata[0], empty[0], level[0], uflow[0]);
      end
      rst_n = 1'b1;
      step(); step();
      checks++;
      if (req[0] !== 1'b0) begin
         failures++;
         $display("FAIL reset_no_req got=%b exp=0", req[0]);
      end
   endtask

   task automatic test_frame;
      int  cyc;
      bit  seen;
      bit  any_req;
      int  exp_len;
      init_done = 1'b1;
      pulse_frame(0);
      for (int k = 0; k < 3; k++) begin
         exp_len = (k == 2) ? 2 : 4;
         wait_req(0, 10, cyc, seen);
         checks++;
         if (!seen || cyc != 1) begin
            failures++;
            $display("FAIL frame_req_latency burst=%0d got seen=%b cyc=%0d exp seen=1 cyc=1", k, seen, cyc);
         end
         checks++;
         if (addr[0] !== BASE + 24'(4 * k) || len[0] !== 9'(exp_len)) begin
            failures++;
            $display("FAIL frame_req_addr_len burst=%0d got addr=%h len=%0d exp addr=%h len=%0d",
                     k, addr[0], len[0], BASE + 24'(4 * k), exp_len);
         end
         ack_req(0);
         send_beats(0, exp_len, 32'(4 * k));
      end
      any_req = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (req[0]) any_req = 1'b1;
         step();
      end
      checks++;
      if (any_req !== 1'b0 || level[0] !== 5'd10) begin
         failures++;
         $display("FAIL frame_done got req_seen=%b level=%0d exp req_seen=0 level=10", any_req, level[0]);
      end
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (pdata[0] !== 32'(i) || empty[0] !== 1'b0) begin
            failures++;
            $display("FAIL frame_pop word=%0d got data=%h empty=%b exp data=%h empty=0", i, pdata[0], empty[0], i);
         end
         rden[0] = 1'b1;
         step();
         rden[0] = 1'b0;
      end
      checks++;
      if (empty[0] !== 1'b1 || level[0] !== 5'd0) begin
         failures++;
         $display("FAIL frame_drained got empty=%b level=%0d exp empty=1 level=0", empty[0], level[0]);
      end
   endtask

   task automatic test_stall;
      int  cyc;
      bit  seen;
      bit  any_req;
      pulse_frame(1);
      for (int k = 0; k < 4; k++) begin
         wait_req(1, 10, cyc, seen);
         checks++;
         if (!seen || addr[1] !== BASE + 24'(4 * k)) begin
            failures++;
            $display("FAIL stall_req burst=%0d got seen=%b addr=%h exp seen=1 addr=%h", k, seen, addr[1], BASE + 24'(4 * k));
         end
         ack_req(1);
         send_beats(1, 4, 32'd100 + 32'(4 * k));
      end
      any_req = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (req[1]) any_req = 1'b1;
         step();
      end
      checks++;
      if (any_req !== 1'b0 || level[1] !== 5'd16) begin
         failures++;
         $display("FAIL stall_full got req_seen=%b level=%0d exp req_seen=0 level=16", any_req, level[1]);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (pdata[1] !== 32'd100 + 32'(i)) begin
            failures++;
            $display("FAIL stall_pop word=%0d got=%h exp=%h", i, pdata[1], 32'd100 + 32'(i));
         end
         rden[1] = 1'b1;
         step();
         rden[1] = 1'b0;
      end
      wait_req(1, 10, cyc, seen);
      checks++;
      if (!seen || addr[1] !== 24'h110 || len[1] !== 9'd4 || level[1] !== 5'd12) begin
         failures++;
         $display("FAIL stall_resume got seen=%b addr=%h len=%0d level=%0d exp seen=1 addr=110 len=4 level=12",
                  seen, addr[1], len[1], level[1]);
      end
   endtask

   task automatic test_flush;
      int  cyc;
      bit  seen;
      pulse_frame(0);
      wait_req(0, 10, cyc, seen);
      checks++;
      if (!seen || addr[0] !== BASE) begin
         failures++;
         $display("FAIL flush_first_req got seen=%b addr=%h exp seen=1 addr=100", seen, addr[0]);
      end
      ack_req(0);
      send_beats(0, 2, 32'hA0);
      checks++;
      if (level[0] !== 5'd2) begin
         failures++;
         $display("FAIL flush_partial_level got=%0d exp=2", level[0]);
      end
      pulse_frame(0);
      checks++;
      if (empty[0] !== 1'b1 || level[0] !== 5'd0 || req[0] !== 1'b0) begin
         failures++;
         $display("FAIL flush_cleared got empty=%b level=%0d req=%b exp 1 0 0", empty[0], level[0], req[0]);
      end
      send_beats(0, 2, 32'hB0);
      checks++;
      if (level[0] !== 5'd0 || req[0] !== 1'b0) begin
         failures++;
         $display("FAIL flush_discard got level=%0d req=%b exp level=0 req=0", level[0], req[0]);
      end
      wait_req(0, 10, cyc, seen);
      checks++;
      if (!seen || addr[0] !== BASE || len[0] !== 9'd4) begin
         failures++;
         $display("FAIL flush_restart got seen=%b addr=%h len=%0d exp seen=1 addr=100 len=4", seen, addr[0], len[0]);
      end
      serve_frame(0);
   endtask

   task automatic test_underflow;
      pulse_frame(0);
      step();
      rden[0] = 1'b1;
      step();
      rden[0] = 1'b0;
      checks++;
      if (uflow[0] !== 1'b1 || pdata[0] !== 32'd0 || level[0] !== 5'd0) begin
         failures++;
         $display("FAIL underflow_set got uflow=%b pdata=%h level=%0d exp uflow=1 pdata=0 level=0",
                  uflow[0], pdata[0], level[0]);
      end
      pulse_frame(0);
      checks++;
      if (uflow[0] !== 1'b0) begin
         failures++;
         $display("FAIL underflow_clear got=%b exp=0", uflow[0]);
      end
      serve_frame(0);
   endtask

   task automatic test_back_to_back;
      int  cyc;
      bit  seen;
      pulse_frame(0);
      wait_req(0, 10, cyc, seen);
      ack_req(0);
      send_beats(0, 4, 32'h10);
      rden[0] = 1'b1;
      step();
      rden[0] = 1'b0;
      checks++;
      if (level[0] !== 5'd3 || pdata[0] !== 32'h11) begin
         failures++;
         $display("FAIL b2b_setup got level=%0d pdata=%h exp level=3 pdata=11", level[0], pdata[0]);
      end
      wait_req(0, 10, cyc, seen);
      checks++;
      if (!seen || addr[0] !== 24'h104) begin
         failures++;
         $display("FAIL b2b_req got seen=%b addr=%h exp seen=1 addr=104", seen, addr[0]);
      end
      ack_req(0);
      dv[0]   = 1'b1;
      dat[0]  = 32'h14;
      rden[0] = 1'b1;
      step();
      dv[0]   = 1'b0;
      rden[0] = 1'b0;
      checks++;
      if (level[0] !== 5'd3 || pdata[0] !== 32'h12) begin
         failures++;
         $display("FAIL b2b_push_pop got level=%0d pdata=%h exp level=3 pdata=12", level[0], pdata[0]);
      end
      send_beats(0, 3, 32'h15);
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (pdata[0] !== 32'h12 + 32'(i)) begin
            failures++;
            $display("FAIL b2b_order word=%0d got=%h exp=%h", i, pdata[0], 32'h12 + 32'(i));
         end
         rden[0] = 1'b1;
         step();
         rden[0] = 1'b0;
      end
   endtask

   task automatic test_reset_mid_burst;
      int  cyc;
      bit  seen;
      bit  any_req;
      pulse_frame(0);
      wait_req(0, 10, cyc, seen);
      ack_req(0);
      send_beats(0, 2, 32'h50);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({req[0], addr[0], len[0], pdata[0], empty[0], level[0], uflow[0]} !==
          {1'b0, BASE, 9'd0, 32'd0, 1'b1, 5'd0, 1'b0}) begin
         failures++;
         $display("FAIL midreset_outputs got req=%b addr=%h len=%0d pdata=%h empty=%b level=%0d uflow=%b exp 0 100 0 0 1 0 0",
                  req[0], addr[0], len[0], pdata[0], empty[0], level[0], uflow[0]);
      end
      step();
      rst_n = 1'b1;
      send_beats(0, 2, 32'h60);
      init_done = 1'b0;
      pulse_frame(0);
      any_req = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (req[0]) any_req = 1'b1;
         step();
      end
      checks++;
      if (any_req !== 1'b0 || level[0] !== 5'd0) begin
         failures++;
         $display("FAIL midreset_idle got req_seen=%b level=%0d exp req_seen=0 level=0", any_req, level[0]);
      end
      init_done = 1'b1;
      pulse_frame(0);
      wait_req(0, 10, cyc, seen);
      checks++;
      if (!seen || addr[0] !== BASE || len[0] !== 9'd4) begin
         failures++;
         $display("FAIL midreset_restart got seen=%b addr=%h len=%0d exp seen=1 addr=100 len=4", seen, addr[0], len[0]);
      end
   endtask

   initial begin
      for (int b = 0; b < 2; b++) begin
         fs[b]   = 1'b0;
         ack[b]  = 1'b0;
         dv[b]   = 1'b0;
         dat[b]  = '0;
         rden[b] = 1'b0;
      end
      test_reset();
      test_frame();
      test_stall();
      test_flush();
      test_underflow();
      test_back_to_back();
      test_reset_mid_burst();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
